cdb_arbiter: RTL and testbench

// - Sits downstream of the reservation stations and functional units. Collects completed results from NUM_FU FUs and grants one per cycle onto the single CDB.
// - Raises a per-FU done pulse that frees the matching RS entry.
// - Each FU has a one-deep holding slot, so a losing FU is stalled through ready/valid, not dropped.

---
 rtl/cdb_arbiter_pkg.sv | 21 ++
 rtl/cdb_arbiter_rr.sv | 29 ++
 rtl/cdb_arbiter.sv | 82 ++++++++
 tb/tb_cdb_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the CDB arbiter: result slots, CDB broadcast packet, done vector.
package cdb_arbiter_pkg;
  localparam int NUM_FU    = 6;
  localparam int ROB_TAG_W = 5;
  localparam int XLEN      = 32;
  localparam int FU_ID_W   = $clog2(NUM_FU + 1);
  localparam int PTR_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [NUM_FU-1:0]    fu_done_packet_t;

  // Tag 0 means "no tag"; an idle CDB carries it.
  localparam rob_tag_t ZERO_REG = '0;

  typedef struct packed {
    logic               valid;
    rob_tag_t           rob_tag;
    logic [XLEN-1:0]    v;
    logic [FU_ID_W-1:0] fu_id;
  } cdb_packet_t;
endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, ascending with wrap.
module rr_arbiter #(
  parameter int N  = 6,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Collects FU results into one-deep slots and broadcasts one per cycle on the CDB, round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [NUM_FU-1:0]                fu_valid,
  input  logic [NUM_FU-1:0][ROB_TAG_W-1:0] fu_rob_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]      fu_value,
  output logic [NUM_FU-1:0]                fu_ready,
  output logic                             cdb_valid,
  output logic [ROB_TAG_W-1:0]             cdb_rob_tag,
  output logic [XLEN-1:0]                  cdb_value,
  output logic [FU_ID_W-1:0]               cdb_fu_id,
  output logic [NUM_FU-1:0]                fu_done
);
  logic [NUM_FU-1:0]            slot_valid;
  rob_tag_t [NUM_FU-1:0]        slot_tag;
  logic [NUM_FU-1:0][XLEN-1:0]  slot_value;
  logic [PTR_W-1:0]             rr_ptr, rr_ptr_nxt, gnt_id;
  logic [NUM_FU-1:0]            arb_grant, grant, accept;
  cdb_packet_t                  cdb;
  fu_done_packet_t              done;

  rr_arbiter #(.N(NUM_FU), .PW(PTR_W)) u_rr (
    .req   (slot_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );

  // Squash suppresses the broadcast, so a granted slot never leaves during a flush.
  assign grant    = squash ? '0 : arb_grant;
  assign fu_ready = (~slot_valid | grant) & {NUM_FU{!squash}};
  assign accept   = fu_valid & fu_ready;

  always_comb begin
    cdb    = '0;
    gnt_id = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        cdb.valid   = 1'b1;
        cdb.rob_tag = slot_tag[i];
        cdb.v       = slot_value[i];
        cdb.fu_id   = FU_ID_W'(i + 1);
        gnt_id      = PTR_W'(i);
      end
    end
    rr_ptr_nxt = (gnt_id == PTR_W'(NUM_FU - 1)) ? '0 : gnt_id + 1'b1;
    done       = grant;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      slot_tag   <= '0;
      slot_value <= '0;
      rr_ptr     <= '0;
    end else if (squash) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        // A refill of a granted slot wins over its clear.
        if (accept[i]) begin
          slot_valid[i] <= 1'b1;
          slot_tag[i]   <= fu_rob_tag[i];
          slot_value[i] <= fu_value[i];
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      if (|grant) rr_ptr <= rr_ptr_nxt;
    end
  end

  assign cdb_valid   = cdb.valid;
  assign cdb_rob_tag = cdb.rob_tag;
  assign cdb_value   = cdb.v;
  assign cdb_fu_id   = cdb.fu_id;
  assign fu_done     = done;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a slot/queue-level reference model checked every cycle.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                             clock = 1'b0;
  logic                             reset = 1'b0;
  logic                             squash = 1'b0;
  logic [NUM_FU-1:0]                fu_valid = '0;
  logic [NUM_FU-1:0][ROB_TAG_W-1:0] fu_rob_tag = '0;
  logic [NUM_FU-1:0][XLEN-1:0]      fu_value = '0;
  logic [NUM_FU-1:0]                fu_ready;
  logic                             cdb_valid;
  logic [ROB_TAG_W-1:0]             cdb_rob_tag;
  logic [XLEN-1:0]                  cdb_value;
  logic [FU_ID_W-1:0]               cdb_fu_id;
  logic [NUM_FU-1:0]                fu_done;

  cdb_arbiter dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_rob_tag(fu_rob_tag), .fu_value(fu_value),
    .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag),
    .cdb_value(cdb_value), .cdb_fu_id(cdb_fu_id), .fu_done(fu_done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each FU owns a pending result; the pointer names who is looked at first.
  bit m_valid[NUM_FU];
  int m_tag[NUM_FU];
  int m_val[NUM_FU];
  int m_ptr = 0;

  function automatic int m_winner();
    for (int off = 0; off < NUM_FU; off++)
      if (m_valid[(m_ptr + off) % NUM_FU]) return (m_ptr + off) % NUM_FU;
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) m_valid[i] = 1'b0;
      m_ptr = 0;
    end else if (squash) begin
      for (int i = 0; i < NUM_FU; i++) m_valid[i] = 1'b0;
      m_ptr = 0;
    end else begin
      int w;
      bit rdy[NUM_FU];
      w = m_winner();
      for (int i = 0; i < NUM_FU; i++) rdy[i] = !m_valid[i] || (i == w);
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && rdy[i]) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = int'(fu_rob_tag[i]);
          m_val[i]   = int'(fu_value[i]);
        end else if (i == w) begin
          m_valid[i] = 1'b0;
        end
      end
      if (w >= 0) m_ptr = (w + 1) % NUM_FU;
    end
  end

  always @(negedge clock) begin
    int w;
    logic [NUM_FU-1:0] exp_ready;
    w = squash ? -1 : m_winner();
    for (int i = 0; i < NUM_FU; i++) exp_ready[i] = !squash && (!m_valid[i] || i == w);
    check("m_cdb_valid", 64'(cdb_valid), 64'(w >= 0));
    check("m_cdb_tag",   64'(cdb_rob_tag), (w >= 0) ? 64'(m_tag[w]) : 64'd0);
    check("m_cdb_value", 64'(cdb_value),   (w >= 0) ? 64'(unsigned'(m_val[w])) : 64'd0);
    check("m_cdb_fu_id", 64'(cdb_fu_id),   (w >= 0) ? 64'(w + 1) : 64'd0);
    check("m_fu_done",   64'(fu_done),     (w >= 0) ? (64'd1 << w) : 64'd0);
    check("m_fu_ready",  64'(fu_ready),    64'(exp_ready));
  end

  always @(negedge clock) begin
    if (!reset)
      for (int i = 0; i < NUM_FU; i++)
        assert (!(fu_valid[i] && fu_rob_tag[i] == ZERO_REG))
          else $error("fu_valid with reserved tag 0 on FU %0d", i);
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic put(input int i, input int tag, input int val);
    fu_valid[i]   = 1'b1;
    fu_rob_tag[i] = ROB_TAG_W'(tag);
    fu_value[i]   = XLEN'(val);
  endtask

  task automatic clr();
    fu_valid = '0; fu_rob_tag = '0; fu_value = '0;
  endtask

  int cnt[NUM_FU];

  initial begin
    #1 reset = 1'b1;
    #20;
    @(negedge clock);
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_fu_ready", 64'(fu_ready), 64'h3f);
    reset = 1'b0;

    // 1: single FU2 result
    step(); put(2, 5, 32'hAA);
    step(); clr();
    @(negedge clock);
    check("t1_valid", 64'(cdb_valid), 64'd1);
    check("t1_tag",   64'(cdb_rob_tag), 64'd5);
    check("t1_value", 64'(cdb_value), 64'hAA);
    check("t1_fu_id", 64'(cdb_fu_id), 64'd3);
    check("t1_done",  64'(fu_done), 64'b000100);
    step(); @(negedge clock);
    check("t1_idle", 64'(cdb_valid), 64'd0);

    // 2: contention, pointer first returned to 0 by a squash
    step(); squash = 1'b1;
    step(); squash = 1'b0;
    put(0, 1, 11); put(3, 4, 44); put(5, 6, 66);
    step(); clr();
    @(negedge clock);
    check("t2_tag0", 64'(cdb_rob_tag), 64'd1);
    check("t2_rdy3_held", 64'(fu_ready[3]), 64'd0);
    step(); @(negedge clock);
    check("t2_tag1", 64'(cdb_rob_tag), 64'd4);
    check("t2_rdy3_grant", 64'(fu_ready[3]), 64'd1);
    step(); @(negedge clock);
    check("t2_tag2", 64'(cdb_rob_tag), 64'd6);

    // 3: FU1 streaming back-to-back
    step(); put(1, 7, 70);
    for (int t = 0; t < 3; t++) begin
      step();
      if (t < 2) put(1, 8 + t, 80 + t); else clr();
      @(negedge clock);
      check("t3_tag", 64'(cdb_rob_tag), 64'(7 + t));
      check("t3_rdy1", 64'(fu_ready[1]), 64'd1);
    end
    step(); @(negedge clock);
    check("t3_idle", 64'(cdb_valid), 64'd0);

    // 5: squash with slots 0 and 4 full
    step(); put(0, 10, 100); put(4, 11, 110);
    step(); clr(); squash = 1'b1;
    @(negedge clock);
    check("t5_valid", 64'(cdb_valid), 64'd0);
    check("t5_ready", 64'(fu_ready), 64'd0);
    check("t5_done",  64'(fu_done), 64'd0);
    step(); squash = 1'b0;
    @(negedge clock);
    check("t5_after_valid", 64'(cdb_valid), 64'd0);
    check("t5_after_ready", 64'(fu_ready), 64'h3f);

    // 4: all FUs valid continuously; pointer is 0 after the squash
    step();
    for (int i = 0; i < NUM_FU; i++) begin put(i, i + 1, 200 + i); cnt[i] = 0; end
    for (int c = 0; c < 12; c++) begin
      step(); @(negedge clock);
      check("t4_fu_id", 64'(cdb_fu_id), 64'(c % NUM_FU + 1));
      for (int i = 0; i < NUM_FU; i++) if (fu_done[i]) cnt[i]++;
      if (c == 5 || c == 11)
        for (int i = 0; i < NUM_FU; i++) check("t4_done_cnt", 64'(cnt[i]), 64'((c + 1) / NUM_FU));
    end
    step(); clr();
    repeat (8) step();

    // 6: async reset with three slots full
    put(1, 20, 1); put(2, 21, 2); put(3, 22, 3);
    step(); clr();
    #1 check("t6_busy", 64'(cdb_valid), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_valid", 64'(cdb_valid), 64'd0);
    check("t6_rst_done",  64'(fu_done), 64'd0);
    check("t6_rst_ready", 64'(fu_ready), 64'h3f);
    step(); reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("t6_no_stale", 64'(cdb_valid), 64'd0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
    $fatal(1, "watchdog");
  end
endmodule
